// File: rtl/travel_plan_seq_if.sv
// Command handshake between the UART wrapper (master) and the travel plan
// sequencer (slave): a level-valid plan word acknowledged by a one-cycle clear.
interface travel_plan_seq_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;

  modport master (output cmd, output cmd_rdy, input clr_cmd_rdy);
  modport slave  (input cmd, input cmd_rdy, output clr_cmd_rdy);
endinterface

// File: rtl/travel_plan_seq.sv
// Maze runner plan sequencer: steps through eight 2-bit turn codes, one per
// confirmed line gap, and stops with the buzzer on when a bump switch closes.
module travel_plan_seq #(
  parameter int                 GAP_CLKS    = 4096,
  parameter int                 SETTLE_CLKS = 65536,
  parameter logic signed [11:0] VEER_OFF    = 12'sd340,
  parameter logic signed [11:0] TURN_OFF    = -12'sd1360,
  parameter int                 CNT_W       = 17
) (
  input  logic                clk,
  input  logic                rst_n,
  travel_plan_seq_if.slave    cmd_bus,
  input  logic                line_present,
  input  logic                BMPL_n,
  input  logic                BMPR_n,
  output logic                go,
  output logic signed [11:0]  steer_off,
  output logic                buzz_en,
  output logic                plan_done,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    TURN   = 3'd2,
    SETTLE = 3'd3,
    BUMPED = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CLKS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CLKS - 1);

  state_t           state;
  logic [15:0]      plan;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             clr_q;
  logic             bump_hit;

  function automatic logic signed [11:0] code_off(input logic [1:0] code);
    case (code)
      2'b01:   return VEER_OFF;
      2'b10:   return -VEER_OFF;
      2'b11:   return TURN_OFF;
      default: return 12'sd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Bumps only matter while the runner is moving; IDLE and BUMPED ignore them.
  assign bump_hit = (!BMPL_n || !BMPR_n) &&
                    (state == RUN || state == TURN || state == SETTLE);

  assign cmd_bus.clr_cmd_rdy = clr_q;
  assign state_dbg           = state;

  // NOTE: every register here is updated with <= so all next-state values are
  // computed from the same pre-edge snapshot, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      plan      <= '0;
      idx       <= '0;
      cnt       <= '0;
      clr_q     <= 1'b0;
      go        <= 1'b0;
      steer_off <= '0;
      buzz_en   <= 1'b0;
      plan_done <= 1'b0;
    end else begin
      clr_q     <= 1'b0;
      plan_done <= 1'b0;
      if (bump_hit) begin
        state     <= BUMPED;
        go        <= 1'b0;
        steer_off <= '0;
        buzz_en   <= 1'b1;
        cnt       <= '0;
      end else begin
        unique case (state)
          IDLE, BUMPED: begin
            if (cmd_bus.cmd_rdy) begin
              plan      <= cmd_bus.cmd;
              idx       <= '0;
              cnt       <= '0;
              clr_q     <= 1'b1;
              go        <= 1'b1;
              steer_off <= '0;
              buzz_en   <= 1'b0;
              state     <= RUN;
            end
          end
          RUN: begin
            if (line_present) begin
              cnt <= '0;
            end else if (cnt == GAP_LAST) begin
              steer_off <= code_off(plan[1:0]);
              plan      <= plan >> 2;
              idx       <= idx + 4'd1;
              cnt       <= '0;
              state     <= TURN;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          TURN: begin
            if (line_present) begin
              cnt   <= '0;
              state <= SETTLE;
            end
          end
          SETTLE: begin
            if (!line_present) begin
              cnt   <= '0;
              state <= TURN;
            end else if (cnt == SETTLE_LAST) begin
              steer_off <= '0;
              cnt       <= '0;
              if (idx == 4'd8) begin
                plan_done <= 1'b1;
                go        <= 1'b0;
                state     <= IDLE;
              end else begin
                state <= RUN;
              end
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_travel_plan_seq.sv
// Scoreboard bench for travel_plan_seq: stimulus pushes expected output events,
// a negedge monitor pops one whenever the registered outputs change or pulse.
module tb_travel_plan_seq;
  localparam int GAP    = 16;
  localparam int SETTLE = 128;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_TURN = 3'd2,
                         S_SETTLE = 3'd3, S_BUMPED = 3'd4;
  localparam logic signed [11:0] OFF_0 = 12'sd0, OFF_R = 12'sd340,
                                 OFF_L = -12'sd340, OFF_T = -12'sd1360;

  typedef struct packed {
    logic        go;
    logic        buzz;
    logic        clr;
    logic        done;
    logic [2:0]  st;
    logic [11:0] off;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic line_present = 1'b1;
  logic BMPL_n = 1'b1;
  logic BMPR_n = 1'b1;
  logic go, buzz_en, plan_done;
  logic signed [11:0] steer_off;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;
  ev_t   exp_q[$];
  string name_q[$];

  always #5 clk = ~clk;

  travel_plan_seq_if bus ();

  travel_plan_seq #(.GAP_CLKS(GAP), .SETTLE_CLKS(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_bus      (bus),
    .line_present (line_present),
    .BMPL_n       (BMPL_n),
    .BMPR_n       (BMPR_n),
    .go           (go),
    .steer_off    (steer_off),
    .buzz_en      (buzz_en),
    .plan_done    (plan_done),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input string name, input logic g, input logic b, input logic c,
                           input logic d, input logic [2:0] st, input logic signed [11:0] off);
    ev_t e;
    e.go = g; e.buzz = b; e.clr = c; e.done = d; e.st = st; e.off = off;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.clr_cmd_rdy) seen = 1'b1;
    end
    bus.cmd_rdy = 1'b0;
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic send_cmd(input logic [15:0] c, input string name);
    bus.cmd     = c;
    bus.cmd_rdy = 1'b1;
    wait_ack(name);
  endtask

  task automatic gap(input int n);
    line_present = 1'b0;
    cycles(n);
    line_present = 1'b1;
  endtask

  // Monitor: any change of go/buzz/state/offset, or a clr/done pulse, is one event.
  initial begin : monitor
    ev_t   prev, cur, e;
    string nm;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {go, buzz_en, bus.clr_cmd_rdy, plan_done, state_dbg, steer_off};
      if (cur.clr || cur.done || cur.go != prev.go || cur.buzz != prev.buzz ||
          cur.st != prev.st || cur.off != prev.off) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got %h expected none", cur);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check(nm, 32'(cur), 32'(e));
        end
      end
      prev = cur;
    end
  end

  initial begin : stimulus
    logic signed [11:0] plan_offs [8];
    plan_offs = '{OFF_T, OFF_L, OFF_R, OFF_0, OFF_T, OFF_L, OFF_R, OFF_0};
    bus.cmd     = '0;
    bus.cmd_rdy = 1'b0;

    #1 rst_n = 1'b0;
    cycles(3);
    check("rst_go",    32'(go),              32'd0);
    check("rst_steer", 32'(steer_off),       32'd0);
    check("rst_buzz",  32'(buzz_en),         32'd0);
    check("rst_clr",   32'(bus.clr_cmd_rdy), 32'd0);
    check("rst_done",  32'(plan_done),       32'd0);
    check("rst_state", 32'(state_dbg),       32'(S_IDLE));
    #2 rst_n = 1'b1;
    cycles(2);

    // Plan 5555: load, a gap one clock short, then one full veer-right gap.
    expect_ev("load_5555", 1, 0, 1, 0, S_RUN, OFF_0);
    send_cmd(16'h5555, "ack_5555");
    cycles(3);
    gap(GAP - 1);
    cycles(3);
    expect_ev("gap_veer_r",    1, 0, 0, 0, S_TURN,   OFF_R);
    expect_ev("settle_veer_r", 1, 0, 0, 0, S_SETTLE, OFF_R);
    expect_ev("run_after_r",   1, 0, 0, 0, S_RUN,    OFF_0);
    gap(GAP);
    cycles(SETTLE + 4);

    // cmd_rdy held in RUN stays pending; a bump then lets BUMPED accept it.
    bus.cmd     = 16'hFFFF;
    bus.cmd_rdy = 1'b1;
    cycles(5);
    expect_ev("bump_in_run", 0, 1, 0, 0, S_BUMPED, OFF_0);
    expect_ev("load_ffff",   1, 0, 1, 0, S_RUN,    OFF_0);
    BMPL_n = 1'b0;
    cycles(1);
    BMPL_n = 1'b1;
    wait_ack("ack_ffff");
    cycles(3);

    // Turn-around with a line dropout 100 clocks into SETTLE.
    expect_ev("gap_turn",       1, 0, 0, 0, S_TURN,   OFF_T);
    expect_ev("settle_turn",    1, 0, 0, 0, S_SETTLE, OFF_T);
    gap(GAP);
    cycles(100);
    expect_ev("dropout_turn",   1, 0, 0, 0, S_TURN,   OFF_T);
    expect_ev("resettle_turn",  1, 0, 0, 0, S_SETTLE, OFF_T);
    expect_ev("run_after_turn", 1, 0, 0, 0, S_RUN,    OFF_0);
    gap(1);
    cycles(SETTLE + 4);

    // Right bump while in TURN, then reload with 1B1B from BUMPED.
    expect_ev("gap_turn2",    1, 0, 0, 0, S_TURN,   OFF_T);
    line_present = 1'b0;
    cycles(GAP + 2);
    expect_ev("bump_in_turn", 0, 1, 0, 0, S_BUMPED, OFF_0);
    BMPR_n = 1'b0;
    cycles(1);
    BMPR_n = 1'b1;
    line_present = 1'b1;
    cycles(3);
    expect_ev("load_1b1b", 1, 0, 1, 0, S_RUN, OFF_0);
    send_cmd(16'h1B1B, "ack_1b1b");
    cycles(3);

    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        gap(GAP - 1);
        cycles(3);
      end
      expect_ev($sformatf("plan_gap%0d", i),    1, 0, 0, 0, S_TURN,   plan_offs[i]);
      expect_ev($sformatf("plan_settle%0d", i), 1, 0, 0, 0, S_SETTLE, plan_offs[i]);
      if (i < 7) expect_ev($sformatf("plan_run%0d", i), 1, 0, 0, 0, S_RUN, OFF_0);
      else       expect_ev("plan_done",                 0, 0, 0, 1, S_IDLE, OFF_0);
      gap(GAP);
      cycles(SETTLE + 4);
    end

    // A bump while idle produces no output change.
    BMPL_n = 1'b0;
    cycles(2);
    BMPL_n = 1'b1;
    cycles(2);

    // Asynchronous reset in the middle of TURN.
    expect_ev("load_5555_b", 1, 0, 1, 0, S_RUN,  OFF_0);
    send_cmd(16'h5555, "ack_5555_b");
    cycles(2);
    expect_ev("gap_veer_r_b", 1, 0, 0, 0, S_TURN, OFF_R);
    line_present = 1'b0;
    cycles(GAP + 3);
    expect_ev("async_reset",  0, 0, 0, 0, S_IDLE, OFF_0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_go",    32'(go),        32'd0);
    check("arst_steer", 32'(steer_off), 32'd0);
    check("arst_buzz",  32'(buzz_en),   32'd0);
    check("arst_state", 32'(state_dbg), 32'(S_IDLE));
    cycles(2);
    #2 rst_n = 1'b1;
    line_present = 1'b1;
    cycles(10);
    check("idle_wait_state", 32'(state_dbg), 32'(S_IDLE));
    check("idle_wait_go",    32'(go),        32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
